// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Generates stall / flush / bubble controls for PC, IF/ID, ID/EX and EX/MEM,
// sequences multi-cycle mul/div occupancy of EX and counts PC-stall cycles.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   RUN     | normal issue; branch, mul/div entry and load-use decided here
//   MD_BUSY | mul/div occupying EX; mdCnt counts down to the final cycle
module pipeline_hazard_ctrl #(
    parameter int REG_W     = 4,
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ID_op1,
    input  logic [REG_W-1:0] ID_op2,
    input  logic             ID_op1_valid,
    input  logic             ID_op2_valid,
    input  logic             ID_EX_memRead,
    input  logic [REG_W-1:0] ID_EX_op1,
    input  logic             ID_EX_muldiv,
    input  logic             EX_branch_taken,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_flush,
    output logic             EX_MEM_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } stateT;

    // The entry cycle in RUN is the first of MD_CYCLES, and the terminal
    // count (0) is the last, so the counter loads MD_CYCLES-2.
    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

    stateT      state;
    stateT      nextState;
    logic [3:0] mdCnt;
    logic [3:0] nextMdCnt;
    logic       loadUse;

    assign loadUse = ID_EX_memRead &&
                     ((ID_op1_valid && (ID_op1 == ID_EX_op1)) ||
                      (ID_op2_valid && (ID_op2 == ID_EX_op1)));

    // State register and mul/div down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            mdCnt <= 4'd0;
        end else begin
            state <= nextState;
            mdCnt <= nextMdCnt;
        end
    end

    // Next-state and counter update; a taken branch outranks mul/div entry.
    always_comb begin
        nextState = state;
        nextMdCnt = mdCnt;
        case (state)
            RUN: begin
                if (!EX_branch_taken && ID_EX_muldiv) begin
                    nextState = MD_BUSY;
                    nextMdCnt = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (mdCnt != 4'd0) begin
                    nextMdCnt = mdCnt - 4'd1;
                end else begin
                    nextState = RUN;
                end
            end
        endcase
    end

    // Control outputs; held at run defaults while reset is asserted so the
    // pipeline sees a clean state before the first clock.
    always_comb begin
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_write   = 1'b1;
        ID_EX_flush   = 1'b0;
        EX_MEM_bubble = 1'b0;
        md_busy       = 1'b0;
        md_done       = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (EX_branch_taken) begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else if (ID_EX_muldiv) begin
                        PC_write      = 1'b0;
                        IF_ID_write   = 1'b0;
                        ID_EX_write   = 1'b0;
                        EX_MEM_bubble = 1'b1;
                    end else if (loadUse) begin
                        PC_write    = 1'b0;
                        IF_ID_write = 1'b0;
                        ID_EX_flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    md_busy = 1'b1;
                    if (mdCnt != 4'd0) begin
                        PC_write      = 1'b0;
                        IF_ID_write   = 1'b0;
                        ID_EX_write   = 1'b0;
                        EX_MEM_bubble = 1'b1;
                    end else begin
                        md_done = 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!PC_write && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: RUN-state decision table plus
// hand-written mul/div, reset and counter-saturation sequences.
module tb_pipeline_hazard_ctrl;

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
    //  EX_MEM_bubble, md_busy, md_done}
    localparam logic [7:0] O_DEF   = 8'b11010000;
    localparam logic [7:0] O_LU    = 8'b00011000;
    localparam logic [7:0] O_BR    = 8'b11111000;
    localparam logic [7:0] O_ENTRY = 8'b00000100;
    localparam logic [7:0] O_BUSY  = 8'b00000110;
    localparam logic [7:0] O_DONE  = 8'b11010011;

    logic       clk;
    logic       rst_n;
    logic [3:0] ID_op1, ID_op2, ID_EX_op1;
    logic       ID_op1_valid, ID_op2_valid, ID_EX_memRead, ID_EX_muldiv, EX_branch_taken;

    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush;
    logic        EX_MEM_bubble, md_busy, md_done;
    logic [15:0] stall_cnt;

    logic        sPC_write, sIF_ID_write, sIF_ID_flush, sID_EX_write, sID_EX_flush;
    logic        sEX_MEM_bubble, sMd_busy, sMd_done;
    logic [3:0]  sStall_cnt;

    logic [7:0]  actOut;
    assign actOut = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
                     EX_MEM_bubble, md_busy, md_done};

    int errors = 0;
    int checks = 0;
    int expCnt = 0;

    pipeline_hazard_ctrl #(.REG_W(4), .MD_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_op1(ID_op1), .ID_op2(ID_op2),
        .ID_op1_valid(ID_op1_valid), .ID_op2_valid(ID_op2_valid),
        .ID_EX_memRead(ID_EX_memRead), .ID_EX_op1(ID_EX_op1),
        .ID_EX_muldiv(ID_EX_muldiv), .EX_branch_taken(EX_branch_taken),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_write(ID_EX_write), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_bubble(EX_MEM_bubble), .md_busy(md_busy), .md_done(md_done),
        .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.REG_W(4), .MD_CYCLES(4), .CNT_W(4)) dutSat (
        .clk(clk), .rst_n(rst_n),
        .ID_op1(ID_op1), .ID_op2(ID_op2),
        .ID_op1_valid(ID_op1_valid), .ID_op2_valid(ID_op2_valid),
        .ID_EX_memRead(ID_EX_memRead), .ID_EX_op1(ID_EX_op1),
        .ID_EX_muldiv(ID_EX_muldiv), .EX_branch_taken(EX_branch_taken),
        .PC_write(sPC_write), .IF_ID_write(sIF_ID_write), .IF_ID_flush(sIF_ID_flush),
        .ID_EX_write(sID_EX_write), .ID_EX_flush(sID_EX_flush),
        .EX_MEM_bubble(sEX_MEM_bubble), .md_busy(sMd_busy), .md_done(sMd_done),
        .stall_cnt(sStall_cnt)
    );

    // 100 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] op1;
        logic [3:0] op2;
        logic       v1;
        logic       v2;
        logic       memRead;
        logic [3:0] exOp1;
        logic       muldiv;
        logic       branch;
        logic [7:0] expOut;
    } vecT;

    vecT vecs[11];

    task automatic checkOut(input logic [7:0] expOut, input string name);
        checks++;
        if (actOut !== expOut) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b", name, actOut, expOut);
        end
    endtask

    task automatic checkCnt(input string name);
        checks++;
        if (stall_cnt !== 16'(expCnt)) begin
            errors++;
            $display("FAIL %s: stall_cnt got %0d expected %0d", name, stall_cnt, expCnt);
        end
    endtask

    // Called at posedge+1 with inputs already applied: checks outputs
    // mid-cycle, then the counter just after the next rising edge.
    task automatic cyc(input logic [7:0] expOut, input string name);
        #2;
        checkOut(expOut, name);
        @(posedge clk);
        #1;
        if (!expOut[7]) expCnt++;
        checkCnt(name);
    endtask

    task automatic clearIn();
        ID_op1 = 4'd0; ID_op2 = 4'd0; ID_EX_op1 = 4'd0;
        ID_op1_valid = 1'b0; ID_op2_valid = 1'b0;
        ID_EX_memRead = 1'b0; ID_EX_muldiv = 1'b0; EX_branch_taken = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, O_DEF};
        vecs[1]  = '{4'd9, 4'd3, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{4'd9, 4'd3, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, O_DEF};
        vecs[3]  = '{4'd2, 4'd7, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, O_LU};
        vecs[4]  = '{4'd2, 4'd7, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, O_DEF};
        vecs[5]  = '{4'd9, 4'd9, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, O_DEF};
        vecs[6]  = '{4'd9, 4'd3, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1, O_BR};
        vecs[7]  = '{4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, O_BR};
        vecs[8]  = '{4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, O_LU};
        vecs[9]  = '{4'd8, 4'd14, 1'b1, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, O_DEF};
        vecs[10] = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, O_BR};

        clearIn();
        rst_n = 1'b0;
        ID_EX_muldiv = 1'b1;

        // Reset held with a mul/div in EX: outputs must stay at defaults.
        repeat (3) @(posedge clk);
        #1;
        checkOut(O_DEF, "reset_defaults");
        checkCnt("reset_cnt");

        // Release: entry, 3 frozen cycles total, done, then back-to-back entry.
        rst_n = 1'b1;
        cyc(O_ENTRY, "md_entry");
        cyc(O_BUSY, "md_busy1");
        cyc(O_BUSY, "md_busy2");
        cyc(O_DONE, "md_done");
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL md_stall3: stall_cnt got %0d expected 3", stall_cnt);
        end
        cyc(O_ENTRY, "md_b2b_entry");
        // Branch and load-use inputs must be ignored while busy.
        ID_EX_muldiv = 1'b0;
        EX_branch_taken = 1'b1;
        cyc(O_BUSY, "md_busy_ign_branch");
        EX_branch_taken = 1'b0;
        ID_EX_memRead = 1'b1; ID_EX_op1 = 4'd6; ID_op1 = 4'd6; ID_op1_valid = 1'b1;
        cyc(O_BUSY, "md_busy_ign_lu");
        cyc(O_DONE, "md_b2b_done");
        clearIn();
        cyc(O_DEF, "after_md");

        // RUN-state decision table.
        for (int i = 0; i < 11; i++) begin
            ID_op1 = vecs[i].op1; ID_op2 = vecs[i].op2;
            ID_op1_valid = vecs[i].v1; ID_op2_valid = vecs[i].v2;
            ID_EX_memRead = vecs[i].memRead; ID_EX_op1 = vecs[i].exOp1;
            ID_EX_muldiv = vecs[i].muldiv; EX_branch_taken = vecs[i].branch;
            cyc(vecs[i].expOut, $sformatf("vec%0d", i));
        end
        clearIn();
        cyc(O_DEF, "after_table");

        // Reset in the middle of a mul/div sequence.
        ID_EX_muldiv = 1'b1;
        cyc(O_ENTRY, "mr_entry");
        cyc(O_BUSY, "mr_busy1");
        #2;
        checkOut(O_BUSY, "mr_busy2");
        rst_n = 1'b0;
        #1;
        expCnt = 0;
        checkOut(O_DEF, "mr_async_defaults");
        checkCnt("mr_async_cnt");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ID_EX_muldiv = 1'b0;
        cyc(O_DEF, "mr_after_release");

        // Counter saturation on the 4-bit instance; 16-bit one keeps counting.
        ID_EX_memRead = 1'b1; ID_EX_op1 = 4'd9; ID_op1 = 4'd9; ID_op1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(O_LU, $sformatf("sat_lu%0d", i));
            if (i == 13) begin
                checks++;
                if (sStall_cnt !== 4'd14) begin
                    errors++;
                    $display("FAIL sat_14: stall_cnt got %0d expected 14", sStall_cnt);
                end
            end
        end
        checks++;
        if (sStall_cnt !== 4'hF) begin
            errors++;
            $display("FAIL sat_hold: stall_cnt got %0d expected 15", sStall_cnt);
        end
        clearIn();
        cyc(O_DEF, "sat_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU. Sits beside the forwarding unit.
- Decides stall, bubble and flush for the IF/ID, ID/EX and EX/MEM registers and the PC, covering:
  - load-use hazards that forwarding cannot cover;
  - taken branches resolved in EX;
  - multi-cycle multiply/divide occupancy of EX.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
- REG_W, 4: register-address width (16-entry register file).
- MD_CYCLES, 4: total cycles a mul/div instruction occupies EX; legal range 2..15.
- CNT_W, 16: stall-counter width.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- ID_op1, input, REG_W: source register 1 of the instruction in ID.
- ID_op2, input, REG_W: source register 2 of the instruction in ID.
- ID_op1_valid, input, 1: ID instruction reads ID_op1.
- ID_op2_valid, input, 1: ID instruction reads ID_op2.
- ID_EX_memRead, input, 1: instruction in EX is a load.
- ID_EX_op1, input, REG_W: destination register of the instruction in EX.
- ID_EX_muldiv, input, 1: instruction in EX is multiply/divide.
- EX_branch_taken, input, 1: branch in EX resolved taken this cycle.
- PC_write, output, 1: 1 = PC updates.
- IF_ID_write, output, 1: 1 = IF/ID register loads.
- IF_ID_flush, output, 1: 1 = IF/ID loads a NOP.
- ID_EX_write, output, 1: 1 = ID/EX register loads.
- ID_EX_flush, output, 1: 1 = ID/EX loads a NOP.
- EX_MEM_bubble, output, 1: 1 = EX/MEM loads a NOP instead of the EX result.
- md_busy, output, 1: mul/div sequence in progress (state MD_BUSY).
- md_done, output, 1: one-cycle pulse on the final mul/div cycle.
- stall_cnt, output, CNT_W: count of cycles with PC_write=0.

Behaviour:
- States: RUN, MD_BUSY. State register and down-counter md_cnt (4 bits) reset asynchronously on rst_n=0 to RUN and 0.
- stall_cnt resets to 0.
- Control outputs are combinational from state, md_cnt and inputs.
- Default values (RUN, no hazard, also while rst_n=0):
  - PC_write=1, IF_ID_write=1, ID_EX_write=1.
  - IF_ID_flush=0, ID_EX_flush=0, EX_MEM_bubble=0.
  - md_busy=0, md_done=0.
- RUN priority 1, branch (EX_branch_taken=1):
  - IF_ID_flush=1, ID_EX_flush=1; PC_write=1 (PC takes the target).
  - Load-use check suppressed. Stay in RUN.
- RUN priority 2, mul/div entry (ID_EX_muldiv=1):
  - PC_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_bubble=1.
  - Next state MD_BUSY; md_cnt <= MD_CYCLES-2.
- RUN priority 3, load-use:
  - Condition: ID_EX_memRead=1 and ((ID_op1_valid and ID_op1==ID_EX_op1) or (ID_op2_valid and ID_op2==ID_EX_op1)).
  - Outputs: PC_write=0, IF_ID_write=0, ID_EX_flush=1 (bubble into EX). Stay in RUN.
  - Exactly one stall cycle: the bubble removes the load from EX compare.
- MD_BUSY with md_cnt>0:
  - md_busy=1, PC_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_bubble=1.
  - md_cnt decrements.
- MD_BUSY with md_cnt==0:
  - md_busy=1, md_done=1; all write enables 1; EX_MEM_bubble=0 (result captured).
  - Next state RUN.
- In MD_BUSY, EX_branch_taken and the load-use compare are ignored; ID_EX holds the mul/div, so they cannot be genuinely active.
- Mul/div total EX occupancy is exactly MD_CYCLES cycles: 1 in RUN + (MD_CYCLES-1) in MD_BUSY. PC frozen for MD_CYCLES-1 cycles.
- Back-to-back mul/div: the second enters EX on the cycle after md_done, and RUN detects it again.
- stall_cnt:
  - Increments on every rising edge where PC_write=0.
  - Saturates at all-ones; no wrap.
- Reset mid-sequence: rst_n=0 in MD_BUSY forces RUN and md_cnt=0 immediately. Outputs return to defaults without waiting for a clock.

Test Plan:
- Reset: hold rst_n=0 with ID_EX_muldiv=1 -> PC_write=1, md_busy=0, stall_cnt=0. Release -> next edge enters MD_BUSY.
- Load-use:
  - ID_EX_memRead=1, ID_EX_op1=4'b1001, ID_op1=4'b1001, ID_op1_valid=1 -> one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cnt becomes 1.
  - Same compare with ID_op1_valid=0 -> no stall.
- Branch over load-use: EX_branch_taken=1 with load-use condition true -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1, stall_cnt unchanged.
- Mul/div, MD_CYCLES=4: ID_EX_muldiv=1 at cycle 0 -> cycles 0-2: PC_write=0, EX_MEM_bubble=1; cycle 3: md_done=1, all writes 1; stall_cnt=3.
- Mid-sequence reset: assert rst_n=0 after 2 MD_BUSY cycles -> immediate RUN defaults; stall_cnt=0.
- Saturation: CNT_W=4, hold load-use true for 20 cycles -> stall_cnt stops at 4'b1111.
